fetch_unit: RTL and testbench
=============================

# fetch_unit

Front-end fetch stage that owns the program counter, drives it to `instruction_cache`, and buffers each returned {PC, instruction} pair in a small FIFO toward decode. It sits directly upstream of `instruction_cache` (supplies `PC`) and also consumes its combinational `instruction` output. It absorbs decode back-pressure and handles branch/jump redirects by flushing the queue.

## Interface
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `QUEUE_DEPTH`, 4: fetch queue entries. Power of two, ≥2.
- `CLK`  input  1  clock; all state updates on rising edge.
- `RESET_N`  input  1  reset, asynchronous, active-low.
- `PC`  output  64  fetch address to `instruction_cache`.
- `instruction`  input  32  instruction word from `instruction_cache`, valid combinationally for the current `PC`.
- `redirect_valid`  input  1  flush the queue and load a new PC.
- `redirect_pc`  input  64  target PC; sampled when `redirect_valid`=1.
- `dec_ready`  input  1  decode accepts the head entry this cycle.
- `dec_valid`  output  1  head entry valid.
- `dec_instruction`  output  32  head entry instruction.
- `dec_pc`  output  64  head entry PC.
- `queue_count`  output  $clog2(QUEUE_DEPTH)+1  number of occupied entries.

## Operation
- Reset (`RESET_N`=0, asynchronous, no clock needed):
  - `PC`=RESET_PC and `queue_count`=0.
  - Read/write pointers are 0 and `dec_valid`=0.
  - `dec_instruction`=0 and `dec_pc`=0, because all entry storage is cleared.
- Pop: occurs when `dec_valid` && `dec_ready`. The head pointer advances by 1 modulo QUEUE_DEPTH.
- Push:
  - Occurs every cycle with no redirect and either `queue_count` < QUEUE_DEPTH or a pop happening in the same cycle (full + pop allows push).
  - Writes {`PC`, `instruction`} at the tail; the tail advances modulo QUEUE_DEPTH.
  - On push, `PC` <= `PC` + 4 (64-bit wrap, no carry-out). With no push, `PC` holds.
- Count update: `queue_count` next = count + push − pop.
- Redirect (`redirect_valid`=1) has highest priority:
  - `PC` <= {`redirect_pc`[63:2], 2'b00}; low bits are forced to zero.
  - Both pointers reset to 0 and `queue_count` <= 0.
  - The instruction present this cycle is not pushed.
  - A decode handshake in the same cycle still completes: the head entry is consumed, and all other entries are discarded.
- Outputs:
  - `dec_valid` = (`queue_count` != 0).
  - `dec_instruction`/`dec_pc` are driven from the head entry storage. They are stable while `dec_valid`=1 and `dec_ready`=0.
- No FSM beyond the queue. Occupancy states and transitions:
  - EMPTY (count 0): push only → PARTIAL; redirect stays EMPTY.
  - PARTIAL: push or pop or both change count by +1/−1/0.
  - FULL (count=QUEUE_DEPTH): fetch stalls unless a pop occurs; redirect → EMPTY.
- Illegal: `redirect_valid` with X on `redirect_pc` is not defined.

## Timing
- The `PC` → `instruction` path is combinational through the cache. The push captures in the same cycle that `PC` is presented.
- Fetch-to-decode latency: `PC` presented in cycle t → `dec_valid`/`dec_pc`=that PC visible from cycle t+1.
- Throughput: one instruction per cycle sustained while `dec_ready`=1.
- Redirect in cycle t:
  - `PC`=`redirect_pc` in t+1.
  - `dec_valid`=0 in t+1.
  - The first redirected instruction is on `dec_*` in t+2.
- Back-pressure: with `dec_ready`=0, the queue fills in QUEUE_DEPTH cycles, then `PC` freezes.
- After full, the first `dec_ready`=1 cycle pops one entry and pushes one entry in the same edge, so count stays full and `PC` advances by 4.
- Reset deassertion: the first push occurs at the first rising edge after `RESET_N` goes high. Reset asserted mid-operation clears the queue immediately, with no partial entries.

## Test plan
- **Reset and stream:** release reset with RESET_PC=0, `dec_ready`=1, and the cache holding the ADDI/JAL program.
  - `PC` takes 0,4,8,… each cycle.
  - `dec_pc` lags `PC` by 1 cycle.
  - `dec_instruction`=32'h00508093 at `dec_pc`=0, then 32'hFFDFF06F at `dec_pc`=4.
- **Back-pressure:** `dec_ready`=0 for 6 cycles from reset.
  - `queue_count` goes 1,2,3,4,4,4.
  - `PC` freezes at 16.
  - `dec_pc` holds 0.
  - Then `dec_ready`=1: entries come out in order 0,4,8,12,16.
- **Full + simultaneous pop/push:** at count=4, pulse `dec_ready` for 1 cycle → count stays 4, `PC` 16→20, and head becomes 4.
- **Redirect:**
  - Setup: count=3, `dec_ready`=1, redirect to 64'h100.
  - Next cycle: `dec_valid`=0 and `PC`=64'h100.
  - The cycle after: `dec_pc`=64'h100.
  - The old head is consumed; no other stale PC is ever output.
- **Misaligned redirect and wrap:**
  - Redirect to 64'h103 → `PC`=64'h100.
  - Redirect to 64'hFFFF_FFFF_FFFF_FFFC with `dec_ready`=1 → next `PC`=0.
- **Async reset mid-stream:** assert `RESET_N`=0 between clock edges with count=2.
  - Immediately: `dec_valid`=0, `queue_count`=0, `PC`=RESET_PC.
  - Resumes fetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
//   Front-end fetch stage. Owns the program counter, presents it to the
//   instruction cache, and captures each {PC, instruction} pair returned
//   combinationally into a small circular queue feeding decode. Redirects
//   flush the queue and reload the PC.
//
// Ports
//   CLK             in   clock, all state on rising edge
//   RESET_N         in   asynchronous active-low reset
//   PC              out  64-bit fetch address to the instruction cache
//   instruction     in   32-bit instruction word for the current PC
//   redirect_valid  in   flush queue and load redirect_pc
//   redirect_pc     in   64-bit redirect target (low two bits ignored)
//   dec_ready       in   decode accepts the head entry this cycle
//   dec_valid       out  head entry valid
//   dec_instruction out  head entry instruction
//   dec_pc          out  head entry PC
//   queue_count     out  number of occupied entries
//
// Queue occupancy (no other FSM in this block)
//   state   | meaning
//   EMPTY   | count 0, dec_valid low, fetch always pushes
//   PARTIAL | 0 < count < QUEUE_DEPTH, push/pop freely
//   FULL    | count == QUEUE_DEPTH, fetch stalls unless decode pops

module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  output logic [63:0]                   PC,
  input  logic [31:0]                   instruction,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_pc,
  input  logic                          dec_ready,
  output logic                          dec_valid,
  output logic [31:0]                   dec_instruction,
  output logic [63:0]                   dec_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  logic [63:0]       pc_q;
  logic [63:0]       pc_d;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic [63:0]       ent_pc    [QUEUE_DEPTH];
  logic [31:0]       ent_instr [QUEUE_DEPTH];

  logic              full;
  logic              pop;
  logic              push;
  logic [63:0]       redirect_target;

  // Handshake decode. A full queue may still accept a fetch when the head
  // leaves on the same edge; the slot being written is the one being freed.
  always_comb begin
    full            = (count_q == FULL_CNT);
    pop             = (count_q != '0) && dec_ready;
    push            = !redirect_valid && (!full || pop);
    redirect_target = redirect_pc & ~64'h3;
  end

  // Next-state computation. Redirect wins over everything: the queue is
  // emptied outright, which also retires a head consumed in the same cycle.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + 64'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is cleared on reset so the head outputs read zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ent_pc[i]    <= '0;
        ent_instr[i] <= '0;
      end
    end else if (push) begin
      ent_pc[wr_ptr_q]    <= pc_q;
      ent_instr[wr_ptr_q] <= instruction;
    end
  end

  always_comb begin
    PC              = pc_q;
    queue_count     = count_q;
    dec_valid       = (count_q != '0);
    dec_pc          = ent_pc[rd_ptr_q];
    dec_instruction = ent_instr[rd_ptr_q];
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit
//   Directed and randomized stimulus for fetch_unit, checked against a
//   queue-based reference model of the fetch stage.

module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [63:0] PC;
  logic [31:0] instruction;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_instruction;
  logic [63:0] dec_pc;
  logic [2:0]  queue_count;

  fetch_unit #(.RESET_PC(64'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .PC              (PC),
    .instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_ready       (dec_ready),
    .dec_valid       (dec_valid),
    .dec_instruction (dec_instruction),
    .dec_pc          (dec_pc),
    .queue_count     (queue_count)
  );

  always #5 CLK = ~CLK;

  // Cache model: ADDI/JAL program at 0/4, address-derived words elsewhere.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    if (a == 64'h0) return 32'h00508093;
    if (a == 64'h4) return 32'hFFDFF06F;
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign instruction = instr_of(PC);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("pc", PC, m_pc);
    chk("count", 64'(queue_count), 64'(q.size()));
    chk("valid", 64'(dec_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("dec_pc", dec_pc, q[0].pc);
      chk("dec_ins", 64'(dec_instruction), 64'(q[0].ins));
    end
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then let the DUT take the same edge and compare.
  task automatic cycle();
    int   n;
    bit   pop;
    ent_t e;
    n   = q.size();
    pop = (n != 0) && dec_ready;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc & ~64'h3;
    end else begin
      if (pop) void'(q.pop_front());
      if (n < DEPTH || pop) begin
        e.pc  = m_pc;
        e.ins = instr_of(m_pc);
        q.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge CLK);
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    RESET_N        = 1'b0;
    redirect_valid = 1'b0;
    #2;
    q.delete();
    m_pc = 64'h0;
    check_model();
    chk("rst_dec_pc", dec_pc, 64'h0);
    chk("rst_dec_ins", 64'(dec_instruction), 64'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  int bp_exp[6] = '{1, 2, 3, 4, 4, 4};

  initial begin
    // Reset and stream
    dec_ready = 1'b1;
    apply_reset();
    cycle();
    chk("stream_pc0", dec_pc, 64'h0);
    chk("stream_ins0", 64'(dec_instruction), 64'h00508093);
    chk("stream_fetch", PC, 64'h4);
    cycle();
    chk("stream_pc4", dec_pc, 64'h4);
    chk("stream_ins4", 64'(dec_instruction), 64'hFFDFF06F);
    for (int i = 0; i < 4; i++) cycle();

    // Back-pressure from reset
    dec_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("bp_count", 64'(queue_count), 64'(bp_exp[i]));
    end
    chk("bp_pc_frozen", PC, 64'd16);
    chk("bp_head", dec_pc, 64'h0);
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_order", dec_pc, 64'(4 * i));
      cycle();
    end

    // Full + simultaneous pop/push
    dec_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) cycle();
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    chk("full_pulse_count", 64'(queue_count), 64'd4);
    chk("full_pulse_pc", PC, 64'd20);
    chk("full_pulse_head", dec_pc, 64'd4);
    cycle();

    // Redirect with count 3 and a same-cycle pop
    apply_reset();
    for (int i = 0; i < 3; i++) cycle();
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_valid", 64'(dec_valid), 64'h0);
    chk("redir_pc", PC, 64'h100);
    cycle();
    chk("redir_head", dec_pc, 64'h100);
    cycle();

    // Misaligned redirect and 64-bit wrap
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    cycle();
    chk("misalign_pc", PC, 64'h100);
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wrap_pc", PC, 64'h0);
    chk("wrap_head", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();

    // Async reset mid-stream
    dec_ready = 1'b0;
    apply_reset();
    cycle();
    cycle();
    chk("pre_async_count", 64'(queue_count), 64'd2);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("async_valid", 64'(dec_valid), 64'h0);
    chk("async_count", 64'(queue_count), 64'h0);
    chk("async_pc", PC, 64'h0);
    q.delete();
    m_pc = 64'h0;
    @(negedge CLK);
    RESET_N   = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic: bursts of stall and flow, occasional redirects
    for (int i = 0; i < 400; i++) begin
      if ((i / 25) % 2 == 0) dec_ready = ($urandom_range(0, 3) != 0);
      else                   dec_ready = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = {$urandom, $urandom};
      cycle();
    end
    redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
